// File: rtl/mips_mem_responder.sv
// Byte-wide program memory for a small MIPS core. After reset a loader
// streams the program image in through a valid/ready port (LOAD); once the
// image is in, the processor is released from reset and gets a simple
// synchronous read/write port onto the same array (RUN).
// Optional build macro: MIPS_MEM_BUSERR_EN adds a sticky bus_err output and
// rejects processor accesses whose upper address bits are nonzero.
module mips_mem_responder #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] adr,
  input  logic [DWIDTH-1:0] writedata,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DWIDTH-1:0] memdata,
  input  logic              load_valid,
  input  logic [DWIDTH-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              cpu_reset_n
`ifdef MIPS_MEM_BUSERR_EN
  ,
  output logic              bus_err
`endif
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ptr_q;
  logic              rdy_q;
  logic [DWIDTH-1:0] mem [2**AWIDTH];

  logic              xfer;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              rd_en;
  logic              addr_ok;
  logic [AWIDTH-1:0] cpu_idx;

  assign cpu_idx = adr[AWIDTH-1:0];

`ifdef MIPS_MEM_BUSERR_EN
  logic [DWIDTH-1:0] adr_hi;
  assign adr_hi  = adr >> AWIDTH;
  assign addr_ok = (adr_hi == '0);
`else
  // Upper address bits alias onto the array.
  logic adr_hi_unused;
  assign adr_hi_unused = |(adr >> AWIDTH);
  assign addr_ok       = 1'b1;
`endif

  // Next-state, handshake/status outputs and memory write-port steering.
  always_comb begin
    state_d     = state_q;
    load_ready  = 1'b0;
    load_done   = 1'b0;
    cpu_reset_n = 1'b0;
    xfer        = 1'b0;
    rd_en       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = cpu_idx;
    mem_wdata   = writedata;
    case (state_q)
      LOAD: begin
        // rdy_q keeps load_ready low until the first edge after reset release.
        load_ready = rdy_q;
        xfer       = load_valid && rdy_q;
        if (xfer) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = load_data;
          if (load_last || (ptr_q == '1)) state_d = RUN;
        end
      end
      RUN: begin
        load_done   = 1'b1;
        cpu_reset_n = 1'b1;
        mem_we      = memwrite && addr_ok;
        rd_en       = memread && !memwrite;
      end
      default: state_d = LOAD;
    endcase
  end

  // FSM state, load pointer and post-reset ready qualifier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (xfer) ptr_q <= ptr_q + 1'b1;
    end
  end

  // Memory array: single write port shared by loader and processor, no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read data; holds when no read is performed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memdata <= '0;
    end else if (rd_en) begin
      memdata <= addr_ok ? mem[cpu_idx] : '0;
    end
  end

`ifdef MIPS_MEM_BUSERR_EN
  // Sticky error flag for out-of-range processor accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err <= 1'b0;
    end else if ((state_q == RUN) && (memread || memwrite) && !addr_ok) begin
      bus_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// Testbench for mips_mem_responder (AWIDTH=5, DWIDTH=8). Honours the
// MIPS_MEM_BUSERR_EN build macro in the same way as the design.
module tb_mips_mem_responder;

  logic       clk;
  logic       rst;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       memread;
  logic       memwrite;
  logic [7:0] memdata;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       load_done;
  logic       cpu_reset_n;
`ifdef MIPS_MEM_BUSERR_EN
  logic       bus_err;
`endif

  mips_mem_responder #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .adr        (adr),
    .writedata  (writedata),
    .memread    (memread),
    .memwrite   (memwrite),
    .memdata    (memdata),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .cpu_reset_n(cpu_reset_n)
`ifdef MIPS_MEM_BUSERR_EN
    ,
    .bus_err    (bus_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, mode, loader position and read register.
  logic [7:0] mmem [32];
  bit         m_run;
  bit         m_rdy;
  int         m_ptr;
  logic [7:0] m_rdata;
  bit         m_berr;
  int         xfers;
  logic [7:0] sent [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_run   = 1'b0;
    m_rdy   = 1'b0;
    m_ptr   = 0;
    m_rdata = 8'h00;
    m_berr  = 1'b0;
  endfunction

  function automatic void model_edge();
    bit hi_err;
    if (!m_run) begin
      if (m_rdy && load_valid) begin
        mmem[m_ptr] = load_data;
        sent.push_back(load_data);
        if (load_last || m_ptr == 31) m_run = 1'b1;
        m_ptr++;
        xfers++;
      end
    end else begin
`ifdef MIPS_MEM_BUSERR_EN
      hi_err = (adr >= 8'd32) && (memread || memwrite);
`else
      hi_err = 1'b0;
`endif
      if (hi_err) begin
        m_berr = 1'b1;
        if (memread && !memwrite) m_rdata = 8'h00;
      end else if (memwrite) begin
        mmem[adr % 32] = writedata;
      end else if (memread) begin
        m_rdata = mmem[adr % 32];
      end
    end
    m_rdy = 1'b1;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".memdata"},     memdata,     m_rdata);
    chk({tag, ".load_done"},   load_done,   m_run);
    chk({tag, ".cpu_reset_n"}, cpu_reset_n, m_run);
    chk({tag, ".load_ready"},  load_ready,  !m_run && m_rdy);
`ifdef MIPS_MEM_BUSERR_EN
    chk({tag, ".bus_err"},     bus_err,     m_berr);
`endif
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("in_reset");
    chk("in_reset.ready_low", load_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick("first_edge");
  endtask

  // Loader stream of n bytes; incrementing data or random data with random gaps.
  task automatic stream(input int n, input bit use_last, input bit rnd);
    int start;
    int budget;
    start  = xfers;
    budget = n * 8 + 10;
    sent.delete();
    while ((xfers - start) < n && budget > 0) begin
      load_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_data  = rnd ? 8'($urandom()) : 8'(m_ptr);
      load_last  = use_last && ((xfers - start) == n - 1);
      tick("stream");
      budget--;
    end
    chk("stream_count", xfers - start, n);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic random_ops(input int n);
    for (int i = 0; i < n; i++) begin
      memread   = 1'($urandom_range(0, 1));
      memwrite  = ($urandom_range(0, 3) == 0);
      adr       = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 31));
      writedata = 8'($urandom());
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 8'($urandom());
      load_last  = 1'($urandom_range(0, 1));
      tick("rand_op");
    end
    memread = 1'b0; memwrite = 1'b0; load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    rst = 1'b0; adr = '0; writedata = '0; memread = 1'b0; memwrite = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    xfers = 0;
    model_reset();
    #2;
    check_all("por");
    chk("por.ready_low", load_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick("first_edge");
    chk("ready_after_edge", load_ready, 1'b1);

    // Full 32-byte image 0x00..0x1F, no load_last.
    stream(32, 1'b0, 1'b0);
    chk("full_load.done", load_done, 1'b1);
    chk("full_load.cpu_rst", cpu_reset_n, 1'b1);
    chk("full_load.ready", load_ready, 1'b0);

    // Loader traffic in RUN is ignored.
    load_valid = 1'b1; load_data = 8'hEE; load_last = 1'b1;
    tick("loader_ignored");
    load_valid = 1'b0; load_last = 1'b0;

    memread = 1'b1; adr = 8'h05;
    tick("rd05");
    chk("rd05.value", memdata, 8'h05);
    memread = 1'b0;
    tick("rd05_hold");
    chk("rd05.hold", memdata, 8'h05);

    memwrite = 1'b1; adr = 8'h03; writedata = 8'hA5;
    tick("wr03");
    memwrite = 1'b0; memread = 1'b1;
    tick("rd03");
    chk("rd03.value", memdata, 8'hA5);
    memwrite = 1'b1; adr = 8'h04; writedata = 8'h3C;
    tick("both04");
    chk("both04.unchanged", memdata, 8'hA5);
    memwrite = 1'b0;
    tick("rd04");
    chk("rd04.value", memdata, 8'h3C);

    adr = 8'h25;
    tick("rd25");
`ifdef MIPS_MEM_BUSERR_EN
    chk("rd25.value", memdata, 8'h00);
    chk("rd25.bus_err", bus_err, 1'b1);
`else
    chk("rd25.value", memdata, 8'h05);
`endif
    memread = 1'b0;

    random_ops(200);

    // Reset in the middle of a load, then a complete reload.
    async_reset();
    stream(10, 1'b0, 1'b1);
    chk("partial.not_done", load_done, 1'b0);
    async_reset();
    chk("restart.ptr_zero", m_ptr, 0);
    stream(32, 1'b0, 1'b1);
    chk("reload.done", load_done, 1'b1);
    random_ops(100);

    // Short image terminated by load_last.
    async_reset();
    stream(4, 1'b1, 1'b1);
    chk("short.done", load_done, 1'b1);
    chk("short.xfers", sent.size(), 4);
    memread = 1'b1; adr = 8'h02;
    tick("short_rd02");
    chk("short_rd02.value", memdata, sent[2]);
    memread = 1'b0;
    random_ops(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter AWIDTH, default 5, meaning memory address bits; depth is 2^AWIDTH bytes.
REQ-002 SHALL have parameter DWIDTH, default 8, meaning data and bus-address width; DWIDTH >= AWIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port adr  input  DWIDTH  byte address from the processor.
REQ-006 SHALL have port writedata  input  DWIDTH  store data from the processor.
REQ-007 SHALL have port memread  input  1  processor read strobe.
REQ-008 SHALL have port memwrite  input  1  processor write strobe.
REQ-009 SHALL have port memdata  output  DWIDTH  registered read data to the processor.
REQ-010 SHALL have port load_valid  input  1  loader byte valid.
REQ-011 SHALL have port load_data  input  DWIDTH  loader byte.
REQ-012 SHALL have port load_last  input  1  marks the final loader byte, qualified by load_valid.
REQ-013 SHALL have port load_ready  output  1  loader may transfer a byte this cycle.
REQ-014 SHALL have port load_done  output  1  program image loaded; processor port live.
REQ-015 SHALL have port cpu_reset_n  output  1  active-low hold for the processor; low until load_done.

Function
REQ-016 SHALL implement a two-state FSM, LOAD and RUN; LOAD is entered on reset.
REQ-017 In LOAD, load_ready SHALL be 1; a transfer occurs when load_valid=1 and load_ready=1.
REQ-018 Each transfer SHALL write load_data to mem[ptr] and increment the AWIDTH-bit pointer ptr by 1.
REQ-019 LOAD SHALL go to RUN on the clock edge of a transfer with load_last=1 or with ptr=2^AWIDTH-1; ptr never wraps to 0 within LOAD.
REQ-020 In RUN: load_ready=0, load_done=1, cpu_reset_n=1; loader inputs ignored; RUN is left only by reset.
REQ-021 In LOAD: memread/memwrite ignored, memdata held at 0, load_done=0, cpu_reset_n=0.
REQ-022 In RUN, memwrite=1 SHALL write writedata to mem[adr[AWIDTH-1:0]] at the same edge.
REQ-023 In RUN, memread=1 with memwrite=0 SHALL load memdata with mem[adr[AWIDTH-1:0]] at that edge; latency is 1 cycle.
REQ-024 memdata SHALL hold its last value when memread=0 or memwrite=1; write wins on simultaneous strobes.
REQ-025 Read immediately after write to the same address SHALL return the new data.
REQ-026 Memory array SHALL have no reset and no contents guarantee before load.

Reset
REQ-027 rst=0 SHALL asynchronously force state=LOAD, ptr=0, memdata=0, load_ready=1 (after the first edge following deassertion; 0 while rst=0), load_done=0, cpu_reset_n=0.
REQ-028 Reset mid-load SHALL restart loading at ptr=0; previously written bytes are don't-care.

Configuration
REQ-029 Macro MIPS_MEM_BUSERR_EN SHALL, when defined, add output bus_err (1 bit, reset 0).
REQ-030 With MIPS_MEM_BUSERR_EN: a RUN access with adr[DWIDTH-1:AWIDTH] nonzero SHALL perform no write, load memdata with 0 on read, and set bus_err sticky until reset.
REQ-031 Without MIPS_MEM_BUSERR_EN: upper address bits SHALL be ignored (aliasing) and no bus_err port exists.

Verification
REQ-032 Reset, stream 32 bytes 0x00..0x1F with load_valid=1, load_last=0 -> load_done=1 and cpu_reset_n=1 the cycle after the 32nd transfer; load_ready=0 thereafter.
REQ-033 After REQ-032, memread=1 adr=0x05 -> memdata=0x05 one cycle later, held after memread drops.
REQ-034 memwrite=1 adr=0x03 writedata=0xA5, next cycle memread adr=0x03 -> memdata=0xA5; memread=memwrite=1 adr=0x04 writedata=0x3C -> memdata unchanged, later read of 0x04 returns 0x3C.
REQ-035 Load 4 bytes with load_last on the 4th -> RUN entered after 4 transfers; read of 0x02 returns the 3rd byte.
REQ-036 rst pulsed low after 10 transfers -> ptr=0, load_done=0, cpu_reset_n=0, memdata=0; reload of 32 bytes completes normally.
REQ-037 Read adr=0x25 in RUN -> with MIPS_MEM_BUSERR_EN memdata=0x00 and bus_err=1 until reset; without it memdata=mem[0x05].
